axil_reg_slave: RTL
===================

# axil_reg_slave

AXI4-Lite responder holding a bank of software-visible 32-bit registers; it is the slave end of the link that the AXI4-Lite master VIP exercises with single-beat writes and reads. It sits behind the block-design interconnect, accepts one write and one read at a time, applies WSTRB byte enables, and returns OKAY or SLVERR. Register contents are exported flat to user logic, with a per-register write-strobe pulse.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2].
- C_NUM_REGS, 4: implemented registers, 1 to 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- reg_q  out  32*C_NUM_REGS  register contents; register k at [32k+31:32k].
- reg_wr  out  C_NUM_REGS  one-cycle pulse, bit k set on the cycle register k commits a write.

## Operation
- Write FSM, all outputs registered:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_HAVE_AW: AWREADY=0, WREADY=1; address captured.
  - W_HAVE_W: AWREADY=1, WREADY=0; data and strobes captured.
  - W_RESP: both ready low, BVALID=1.
- Write transitions:
  - W_IDLE with both handshakes on one edge -> W_RESP.
  - AW handshake only -> W_HAVE_AW; W handshake only -> W_HAVE_W.
  - W_HAVE_AW or W_HAVE_W -> W_RESP on the missing handshake.
  - W_RESP -> W_IDLE on BVALID&BREADY.
- Commit happens on the edge entering W_RESP, using captured or live address, data and strobes. Bytes with WSTRB=0 are unchanged; WSTRB=0000 is a legal no-op with OKAY.
- Index >= C_NUM_REGS: no register changes, reg_wr stays 0, BRESP=SLVERR.
- Read FSM:
  - R_IDLE: ARREADY=1.
  - R_RESP: ARREADY=0, RVALID=1.
  - R_IDLE -> R_RESP on AR handshake; RDATA/RRESP are latched from the register values before that edge.
  - R_RESP -> R_IDLE on RVALID&RREADY.
- Out-of-range read: RDATA=0, RRESP=SLVERR.
- Read and write paths are fully independent. A read and a write committing the same register on the same edge: the read returns the old value.
- RDATA, BRESP and RRESP hold stable while VALID is high and READY is low.

## Timing
- While ARESET is high: registers, reg_q and reg_wr = 0; all READY and VALID = 0; RDATA, BRESP and RRESP = 0; both FSMs in IDLE.
- AWREADY, WREADY and ARREADY first rise on the edge after the first edge with ARESET low.
- Write latency: BVALID is high the cycle after the completing handshake edge. reg_q updates and reg_wr pulses in that same cycle.
- Read latency: RVALID is high the cycle after the AR handshake edge.
- Back-to-back throughput: one write per 2 cycles and one read per 2 cycles, with BREADY/RREADY held high. The next readies assert the cycle after the B/R handshake.
- BVALID and RVALID never drop without a handshake except on reset.
- Reset asserted mid-transaction aborts it: no response is issued and captured address/data are discarded. Master-side valid signals held across reset are accepted afresh once the readies return.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read all four -> each BRESP=00; reads return 0x1 to 0x4 with RRESP=00; reg_wr pulses bits 0 to 3 in order.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB=0101 -> readback 0xFF34FF78.
- AWVALID 3 cycles before WVALID, then W 3 cycles before AW -> W_HAVE_AW and W_HAVE_W paths each commit correctly; BVALID one cycle after the second handshake.
- BREADY low 5 cycles, then RREADY low 5 cycles -> BVALID/RVALID and BRESP/RDATA held stable; readies stay low until the handshake.
- Register 0x8 holds 0xA; on one edge, AR to 0x8 and a write of 0xB to 0x8 complete -> RDATA=0xA, subsequent read returns 0xB.
- With C_NUM_REGS=3, write and read 0xC -> BRESP=10, RRESP=10, RDATA=0, no reg_wr. Separately, assert ARESET during W_HAVE_AW -> no BVALID, all registers 0, readies return after reset.

Source files
------------

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank responder with byte-strobed writes and flat register export.
// Ports: ACLK/ARESET, S_AXI_* AW/W/B/AR/R channels, reg_q (all registers), reg_wr (commit pulses).
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] reg_q,
    output logic [C_NUM_REGS-1:0]                  reg_wr
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    // Low for the first cycle out of reset so the readies rise one edge later.
    logic live_q;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;

    logic awready_q, awready_d;
    logic wready_q, wready_d;
    logic bvalid_q, bvalid_d;
    logic arready_q, arready_d;
    logic rvalid_q, rvalid_d;

    logic [AW-1:0] awaddr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic [1:0]    bresp_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    logic [DW-1:0]         regs_q [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] reg_wr_q, reg_wr_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign b_hs  = bvalid_q & S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID & arready_q;
    assign r_hs  = rvalid_q & S_AXI_RREADY;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write FSM: state and registered outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            live_q    <= 1'b0;
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Write FSM: next state.
    always_comb begin
        wstate_d = wstate_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wstate_d = W_RESP;
                else if (aw_hs)    wstate_d = W_HAVE_AW;
                else if (w_hs)     wstate_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  wstate_d = W_RESP;
            W_HAVE_W:  if (aw_hs) wstate_d = W_RESP;
            W_RESP:    if (b_hs)  wstate_d = W_IDLE;
            default:   wstate_d = W_IDLE;
        endcase
    end

    // Write FSM: outputs decoded from the next state, then registered.
    always_comb begin
        awready_d = live_q & ((wstate_d == W_IDLE) | (wstate_d == W_HAVE_W));
        wready_d  = live_q & ((wstate_d == W_IDLE) | (wstate_d == W_HAVE_AW));
        bvalid_d  = (wstate_d == W_RESP);
    end

    // Commit uses whichever of address/data arrives on the completing edge live.
    logic          commit;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    logic [SW-1:0] c_strb;
    logic [IW-1:0] c_idx;
    logic          c_ok;

    assign commit = (wstate_d == W_RESP) && (wstate_q != W_RESP);
    assign c_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign c_data = w_hs ? S_AXI_WDATA : wdata_q;
    assign c_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
    assign c_idx  = c_addr[AW-1:2];
    assign c_ok   = ({1'b0, c_idx} < (IW+1)'(C_NUM_REGS));

    always_comb begin
        reg_wr_d = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            reg_wr_d[k] = commit & c_ok & (c_idx == IW'(k));
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            reg_wr_q <= '0;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            if (aw_hs) awaddr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) bresp_q <= c_ok ? OKAY : SLVERR;
            reg_wr_q <= reg_wr_d;
            for (int k = 0; k < C_NUM_REGS; k++) begin
                for (int b = 0; b < SW; b++) begin
                    if (reg_wr_d[k] && c_strb[b]) begin
                        regs_q[k][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read FSM: state and registered outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Read FSM: next state.
    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_RESP;
            R_RESP:  if (r_hs)  rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read FSM: outputs.
    always_comb begin
        arready_d = live_q & (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_RESP);
    end

    // Read mux sees pre-edge register values, so a same-edge write is not visible.
    logic [IW-1:0] r_idx;
    logic          r_ok;
    logic [DW-1:0] r_data;

    assign r_idx = S_AXI_ARADDR[AW-1:2];
    assign r_ok  = ({1'b0, r_idx} < (IW+1)'(C_NUM_REGS));

    always_comb begin
        r_data = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (r_idx == IW'(k)) r_data = regs_q[k];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= r_data;
            rresp_q <= r_ok ? OKAY : SLVERR;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr        = reg_wr_q;

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
        assign reg_q[DW*k +: DW] = regs_q[k];
    end

endmodule
